region_restore_engine: RTL and testbench

- Parametrised rectangular-region redraw engine and the successor of the fixed-window erase block.
- On `start`, it latches a runtime rectangle (origin, width, height) and raster-scans it.
- COPY mode reads each pixel's colour from a screen-sized background RAM; FILL mode uses a constant colour.
- It drives VGA-adapter plot signals (`x`, `y`, `colour`, `plot`), clips to the screen and reports completion with a `busy`/`done` handshake.
- It sits between the game FSM and the VGA adapter, next to the sprite drawers.

---
 rtl/region_restore_if.sv | 35 +++
 rtl/region_restore_engine.sv | 163 ++++++++++++++++
 tb/tb_region_restore_engine.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/region_restore_if.sv
// Handshake, RAM read port and VGA plot port of the region restore engine,
// bundled so the game FSM / RAM / VGA side and the engine connect as one unit.
interface region_restore_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 9,
  parameter int ADDR_W   = 15
);
  logic                start;
  logic                mode;
  logic [X_W-1:0]      x0;
  logic [Y_W-1:0]      y0;
  logic [X_W-1:0]      w;
  logic [Y_W-1:0]      h;
  logic [COLOUR_W-1:0] fill_colour;
  logic [COLOUR_W-1:0] rd_data;
  logic [ADDR_W-1:0]   rd_addr;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                done;

  // master: requester plus background RAM; slave: the engine
  modport master (
    output start, mode, x0, y0, w, h, fill_colour, rd_data,
    input  rd_addr, x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, mode, x0, y0, w, h, fill_colour, rd_data,
    output rd_addr, x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/region_restore_engine.sv
// Raster-scans a runtime rectangle, plotting either background-RAM pixels (COPY)
// or a constant colour (FILL), clipping to the screen; busy/done handshake.
module region_restore_engine #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 9,
  parameter int ADDR_W   = 15,
  parameter int RD_LAT   = 1
) (
  input logic             clk,
  input logic             rst,
  region_restore_if.slave rr
);
  localparam int CX_W   = X_W + 1;
  localparam int CY_W   = Y_W + 1;
  localparam int META_W = X_W + Y_W + 2;
  localparam int VLD_B  = META_W - 1;
  localparam int INB_B  = META_W - 2;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t              state_q;
  logic                mode_q;
  logic [COLOUR_W-1:0] fill_q;
  logic [CX_W-1:0]     x0_q;
  logic [CX_W-1:0]     x_last_q;
  logic [CX_W-1:0]     cx_q;
  logic [CY_W-1:0]     y_last_q;
  logic [CY_W-1:0]     cy_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   rd_addr_d;
  logic                busy_q;
  logic                done_q;
  logic                inb_d;
  logic                dl_busy;
  logic [META_W-1:0]   dl_d;
  logic [RD_LAT:0][META_W-1:0] dl_q;
  logic [RD_LAT:0]     stage_vld;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                plot_q;

  always_comb begin
    rd_addr_d = ADDR_W'(32'(cy_q) * 32'(SCREEN_W) + 32'(cx_q));
    inb_d     = (32'(cx_q) < 32'(SCREEN_W)) && (32'(cy_q) < 32'(SCREEN_H));
    dl_d      = {state_q == SCAN, inb_d, cx_q[X_W-1:0], cy_q[Y_W-1:0]};
  end

  genvar gi;
  generate
    for (gi = 0; gi <= RD_LAT; gi++) begin : g_vld
      assign stage_vld[gi] = dl_q[gi][VLD_B];
    end
  endgenerate

  assign dl_busy = |stage_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      fill_q    <= '0;
      x0_q      <= '0;
      x_last_q  <= '0;
      y_last_q  <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rr.start) begin
            mode_q   <= rr.mode;
            fill_q   <= rr.fill_colour;
            x0_q     <= {1'b0, rr.x0};
            cx_q     <= {1'b0, rr.x0};
            cy_q     <= {1'b0, rr.y0};
            x_last_q <= {1'b0, rr.x0} + {1'b0, rr.w} - CX_W'(1);
            y_last_q <= {1'b0, rr.y0} + {1'b0, rr.h} - CY_W'(1);
            if (rr.w == '0 || rr.h == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SCAN;
              busy_q  <= 1'b1;
            end
          end
        end
        SCAN: begin
          // clipped pixels still take their cycle so timing depends only on w*h
          rd_addr_q <= rd_addr_d;
          if (cx_q == x_last_q) begin
            cx_q <= x0_q;
            if (cy_q == y_last_q) begin
              state_q <= DRAIN;
            end else begin
              cy_q <= cy_q + CY_W'(1);
            end
          end else begin
            cx_q <= cx_q + CX_W'(1);
          end
        end
        DRAIN: begin
          // last entry leaves the delay line in the same cycle it reaches the plot register
          if (!dl_busy) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // entry 0 rides alongside rd_addr; entries 1..RD_LAT cover the RAM latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_q <= '0;
    end else begin
      dl_q[0] <= dl_d;
      for (int i = 1; i <= RD_LAT; i++) begin
        dl_q[i] <= dl_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      plot_q <= 1'b0;
      if (dl_q[RD_LAT][VLD_B]) begin
        x_q      <= dl_q[RD_LAT][X_W+Y_W-1:Y_W];
        y_q      <= dl_q[RD_LAT][Y_W-1:0];
        colour_q <= mode_q ? fill_q : rr.rd_data;
        plot_q   <= dl_q[RD_LAT][INB_B];
      end
    end
  end

  assign rr.rd_addr = rd_addr_q;
  assign rr.x       = x_q;
  assign rr.y       = y_q;
  assign rr.colour  = colour_q;
  assign rr.plot    = plot_q;
  assign rr.busy    = busy_q;
  assign rr.done    = done_q;
endmodule

// File: tb/tb_region_restore_engine.sv
// Three engines with RD_LAT = 1, 2, 3 driven in lockstep; a scoreboard per lane
// holds the expected plotted pixels and a negedge monitor pops and compares them.
module tb_region_restore_engine;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic [7:0] x0_s;
  logic [6:0] y0_s;
  logic [7:0] w_s;
  logic [6:0] h_s;
  logic [8:0] fill_s;
  int         cyc = 0;

  logic        plot_w [3];
  logic        busy_w [3];
  logic        done_w [3];
  logic [7:0]  x_w    [3];
  logic [6:0]  y_w    [3];
  logic [8:0]  col_w  [3];
  logic [14:0] addr_w [3];

  logic [23:0] exp_q [3][$];
  int          plot_cnt [3];
  int          done_cnt [3];
  int          done_cyc [3];
  int          first_plot_cyc [3];
  int          last_plot_cyc [3];
  logic        busy_seen [3];
  logic        busy_at_done [3];
  logic [14:0] first_addr [3];
  logic [14:0] last_addr [3];

  int          n_tests;
  int          n_fail;
  int          start_cyc;
  int          scan_len;
  int          exp_cnt;
  logic        first_in;
  logic [14:0] exp_first_addr;
  logic [14:0] exp_last_addr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] ram_fn(input logic [14:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd37 + 32'(a >> 5);
    return t[8:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : lane
      localparam int LAT = gi + 1;
      region_restore_if #(.X_W(8), .Y_W(7), .COLOUR_W(9), .ADDR_W(15)) rr ();
      logic [8:0] rp [0:2];

      region_restore_engine #(
        .SCREEN_W(160), .SCREEN_H(120), .X_W(8), .Y_W(7),
        .COLOUR_W(9), .ADDR_W(15), .RD_LAT(LAT)
      ) dut (
        .clk(clk),
        .rst(rst),
        .rr (rr)
      );

      assign rr.start       = start;
      assign rr.mode        = mode;
      assign rr.x0          = x0_s;
      assign rr.y0          = y0_s;
      assign rr.w           = w_s;
      assign rr.h           = h_s;
      assign rr.fill_colour = fill_s;

      // background RAM with LAT cycles of read latency
      always @(posedge clk) begin
        rp[0] <= ram_fn(rr.rd_addr);
        rp[1] <= rp[0];
        rp[2] <= rp[1];
      end
      assign rr.rd_data = rp[LAT-1];

      assign plot_w[gi] = rr.plot;
      assign busy_w[gi] = rr.busy;
      assign done_w[gi] = rr.done;
      assign x_w[gi]    = rr.x;
      assign y_w[gi]    = rr.y;
      assign col_w[gi]  = rr.colour;
      assign addr_w[gi] = rr.rd_addr;
    end
  endgenerate

  task automatic check(input string name, input int l, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s lane%0d (RD_LAT=%0d): got %0d, required %0d", name, l, l + 1, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int l = 0; l < 3; l++) begin
        if (busy_w[l]) busy_seen[l] = 1'b1;
        if (cyc == start_cyc + 1) first_addr[l] = addr_w[l];
        if (cyc == start_cyc + scan_len) last_addr[l] = addr_w[l];
        if (done_w[l]) begin
          done_cnt[l]++;
          done_cyc[l]     = cyc;
          busy_at_done[l] = busy_w[l];
        end
        if (plot_w[l]) begin
          logic [23:0] e;
          if (plot_cnt[l] == 0) first_plot_cyc[l] = cyc;
          last_plot_cyc[l] = cyc;
          plot_cnt[l]++;
          n_tests++;
          if (exp_q[l].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_plot lane%0d: got plot at (%0d,%0d), required no plot",
                     l, x_w[l], y_w[l]);
          end else begin
            e = exp_q[l].pop_front();
            if ({x_w[l], y_w[l], col_w[l]} !== e) begin
              n_fail++;
              $display("FAIL pixel lane%0d: got (%0d,%0d) colour %h, required (%0d,%0d) colour %h",
                       l, x_w[l], y_w[l], col_w[l], e[23:16], e[15:9], e[8:0]);
            end
          end
          check("busy_during_plot", l, 32'(busy_w[l]), 32'd1);
        end
      end
    end
  end

  task automatic clear_stats();
    for (int l = 0; l < 3; l++) begin
      exp_q[l].delete();
      plot_cnt[l]       = 0;
      done_cnt[l]       = 0;
      done_cyc[l]       = -1;
      first_plot_cyc[l] = -1;
      last_plot_cyc[l]  = -1;
      busy_seen[l]      = 1'b0;
      busy_at_done[l]   = 1'b1;
      first_addr[l]     = '1;
      last_addr[l]      = '1;
    end
  endtask

  task automatic setup_region(input logic m, input int x0, input int y0, input int w, input int h,
                              input logic [8:0] fc);
    logic [8:0] c;
    clear_stats();
    exp_cnt = 0;
    for (int yy = y0; yy < y0 + h; yy++) begin
      for (int xx = x0; xx < x0 + w; xx++) begin
        if (xx < 160 && yy < 120) begin
          c = m ? fc : ram_fn(15'(yy * 160 + xx));
          for (int l = 0; l < 3; l++) exp_q[l].push_back({8'(xx), 7'(yy), c});
          exp_cnt++;
        end
      end
    end
    first_in       = (x0 < 160) && (y0 < 120);
    scan_len       = w * h;
    exp_first_addr = 15'(y0 * 160 + x0);
    exp_last_addr  = 15'((y0 + h - 1) * 160 + x0 + w - 1);
    mode   = m;
    x0_s   = 8'(x0);
    y0_s   = 7'(y0);
    w_s    = 8'(w);
    h_s    = 7'(h);
    fill_s = fc;
    $display("[TB] region mode=%0d origin=(%0d,%0d) size=%0dx%0d: %0d plots expected",
             m, x0, y0, w, h, exp_cnt);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_region(input int spur);
    logic all_done;
    int   bound;
    all_done = 1'b0;
    bound    = scan_len + 40;
    for (int t = 0; t < bound && !all_done; t++) begin
      @(negedge clk);
      #1;
      if (t == spur) begin
        start = 1'b1;
        x0_s  = 8'd0;
        y0_s  = 7'd0;
        w_s   = 8'd2;
        h_s   = 7'd2;
      end else begin
        start = 1'b0;
      end
      all_done = (done_cnt[0] > 0) && (done_cnt[1] > 0) && (done_cnt[2] > 0);
    end
    start = 1'b0;
    if (!all_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done within %0d cycles, required done", bound);
    end
    repeat (6) @(negedge clk);
    #1;
    for (int l = 0; l < 3; l++) begin
      check("done_count", l, 32'(done_cnt[l]), 32'd1);
      check("busy_at_done", l, 32'(busy_at_done[l]), 32'd0);
      check("plot_count", l, 32'(plot_cnt[l]), 32'(exp_cnt));
      check("scoreboard_left", l, 32'(exp_q[l].size()), 32'd0);
      if (scan_len == 0) begin
        check("done_cycle", l, 32'(done_cyc[l] - start_cyc), 32'd0);
        check("busy_seen", l, 32'(busy_seen[l]), 32'd0);
      end else begin
        check("done_cycle", l, 32'(done_cyc[l] - start_cyc), 32'(scan_len + l + 3));
        check("first_rd_addr", l, 32'(first_addr[l]), 32'(exp_first_addr));
        check("last_rd_addr", l, 32'(last_addr[l]), 32'(exp_last_addr));
        if (first_in) check("first_plot_cycle", l, 32'(first_plot_cyc[l] - start_cyc), 32'(l + 3));
        if (exp_cnt == scan_len)
          check("plot_run_length", l, 32'(last_plot_cyc[l] - first_plot_cyc[l]), 32'(exp_cnt - 1));
      end
    end
  endtask

  task automatic run_region(input logic m, input int x0, input int y0, input int w, input int h,
                            input logic [8:0] fc, input int spur);
    setup_region(m, x0, y0, w, h, fc);
    pulse_start();
    finish_region(spur);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    start     = 1'b0;
    mode      = 1'b0;
    x0_s      = '0;
    y0_s      = '0;
    w_s       = '0;
    h_s       = '0;
    fill_s    = '0;
    start_cyc = -100;
    scan_len  = 0;
    clear_stats();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      check("reset_ctrl", l, 32'({plot_w[l], busy_w[l], done_w[l], addr_w[l]}), 32'd0);
      check("reset_pixel", l, 32'({x_w[l], y_w[l], col_w[l]}), 32'd0);
    end
    rst = 1'b0;
    #1;

    run_region(1'b0, 39, 39, 81, 41, 9'h000, -1);
    run_region(1'b1, 0, 0, 4, 2, 9'h1C0, -1);
    run_region(1'b0, 150, 118, 20, 4, 9'h000, -1);
    run_region(1'b0, 20, 30, 0, 5, 9'h000, -1);
    run_region(1'b1, 20, 30, 6, 0, 9'h0AA, -1);
    run_region(1'b1, 10, 10, 5, 3, 9'h155, 4);

    // abort mid-scan on the 100th plot of the RD_LAT=1 lane
    setup_region(1'b0, 39, 39, 81, 41, 9'h000);
    pulse_start();
    repeat (102) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    for (int l = 0; l < 3; l++) begin
      check("midscan_reset_ctrl", l, 32'({plot_w[l], busy_w[l], done_w[l]}), 32'd0);
      check("midscan_reset_addr", l, 32'(addr_w[l]), 32'd0);
    end
    @(negedge clk);
    clear_stats();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    for (int l = 0; l < 3; l++) begin
      check("no_plot_after_reset", l, 32'(plot_cnt[l]), 32'd0);
    end
    run_region(1'b0, 5, 7, 12, 3, 9'h000, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
